io_loader: RTL and testbench
============================

Name: io_loader

Overview:
Host-side loader that sits directly upstream of the CPU core's I/O interface.
- Accepts a byte stream from a host link using a valid/ready handshake.
- Assembles framed bytes into full instruction or data words.
- Drives the core's interrupt/io_inst pair to inject instructions and the io_din bus to supply data words.
- Flags framing errors and end-of-load to the host side.

Parameters:
BIT_INST, 32, instruction word width; must be a multiple of 8.
BIT_DATA, 32, data word width; must be a multiple of 8.
HOLD_CYC, 2, number of cycles interrupt and io_inst are held for each injected instruction; must be at least 1.
TIMEOUT, 16, idle cycles allowed mid-frame before the frame is aborted; must be at least 1.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
rx_valid  input  1  host byte valid.
rx_byte  input  8  host byte.
rx_ready  output  1  loader can accept a byte this cycle.
interrupt  output  1  instruction injection strobe to the core.
io_inst  output  BIT_INST  injected instruction word.
io_din  output  BIT_DATA  last fully received data word.
data_stb  output  1  one-cycle pulse when io_din updates.
err  output  1  one-cycle pulse on a framing error.
done  output  1  sticky end-of-load flag.
inst_cnt  output  16  count of instructions injected; wraps.

Behaviour:
- One clock; reset is synchronous and active-high. There is no asynchronous path.
- Reset values: interrupt, data_stb, err and done are 0. io_inst, io_din and inst_cnt are 0. State is IDLE.
- rx_ready = !reset && (state == IDLE || state == PAYLOAD).
- A byte is accepted on the rising edge where rx_valid && rx_ready.
- Frame format: one header byte, then payload bytes, most-significant byte first. The header is decoded from bits [7:6]:
  - 00: instruction frame, BIT_INST/8 payload bytes.
  - 01: data frame, BIT_DATA/8 payload bytes.
  - 10: end-of-load, no payload. done <= 1. Stay in IDLE.
  - 11: reserved. err pulses 1 cycle. Stay in IDLE.
  - Header bits [5:0] are ignored.
- done clears on acceptance of any subsequent header byte.
- States:
  - IDLE: wait for a header. A header of type 00 or 01 moves to PAYLOAD, clears the byte counter and latches the frame type.
  - PAYLOAD: each accepted byte shifts into an internal assembly register, which is separate from io_inst and io_din. The timeout counter clears on every accepted byte and increments on every other cycle.
    - Last byte of an instruction frame, accepted at edge N: io_inst <= assembled word, interrupt <= 1 and inst_cnt += 1, all at edge N. State moves to ISSUE.
    - Last byte of a data frame at edge N: io_din <= assembled word and data_stb <= 1 at edge N. State returns to IDLE, so a new header is accepted from cycle N+1.
    - Timeout counter reaches TIMEOUT: err pulses 1 cycle, the partial word is discarded, io_inst and io_din are unchanged, and state returns to IDLE.
  - ISSUE: interrupt is high for exactly HOLD_CYC cycles with io_inst stable, then interrupt <= 0 and state moves to GAP.
  - GAP: one cycle with interrupt low, then IDLE. This guarantees a falling edge between back-to-back instructions.
- io_inst holds its value after ISSUE until the next instruction frame completes. io_din holds until the next data frame completes.
- inst_cnt wraps from 0xFFFF to 0x0000.
- A reset asserted at any point, including mid-frame or during ISSUE, returns all outputs to their reset values on that edge and discards partial payloads.
- Simultaneous events:
  - A timeout and a byte arrival on the same cycle: the byte wins and the counter clears.
  - rx_valid is ignored while rx_ready = 0; the host must hold the byte.

Test Plan:
1. Reset, then send 0x00, DE, AD, BE, EF -> io_inst = 0xDEADBEEF and interrupt = 1 for exactly 2 cycles, starting the cycle after EF is accepted. rx_ready = 0 for 3 cycles. inst_cnt = 1.
2. Send 0x40, 12, 34, 56, 78 -> io_din = 0x12345678 and data_stb = 1 for one cycle. interrupt stays 0. rx_ready never drops.
3. Send 0x00, 11, 22, then hold rx_valid = 0 for 16 cycles -> err = 1 for one cycle and io_inst is unchanged. A following frame 0x00, 01, 02, 03, 04 gives io_inst = 0x01020304.
4. Send 0xC0 -> one err pulse and no state change. Send 0x80 -> done = 1 and stays 1. Send 0x40 -> done = 0 on that edge.
5. Assert reset after 0x00, AA, BB -> all outputs are 0 on the next edge. Then 0x00, 00, 00, 00, 2A gives io_inst = 0x0000002A and inst_cnt = 1.
6. Hold rx_valid high and stream two instruction frames back-to-back -> bytes stall during ISSUE/GAP, two separate 2-cycle interrupt pulses are separated by at least 1 low cycle, inst_cnt = 2, and no bytes are lost.

Source files
------------

// File: rtl/io_loader.sv
// io_loader: host-side byte loader in front of the CPU core I/O port.
// Collects framed bytes (header + MSB-first payload) from a valid/ready
// link, injects complete instruction words through interrupt/io_inst and
// publishes complete data words on io_din. Framing errors and
// end-of-load are reported back toward the host.
module io_loader #(
   parameter int BIT_INST = 32,
   parameter int BIT_DATA = 32,
   parameter int HOLD_CYC = 2,
   parameter int TIMEOUT  = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                rx_valid,
   input  logic [7:0]          rx_byte,
   output logic                rx_ready,
   output logic                interrupt,
   output logic [BIT_INST-1:0] io_inst,
   output logic [BIT_DATA-1:0] io_din,
   output logic                data_stb,
   output logic                err,
   output logic                done,
   output logic [15:0]         inst_cnt
);

   // The assembly register is as wide as the larger of the two word types.
   localparam int ASM_W      = (BIT_INST > BIT_DATA) ? BIT_INST : BIT_DATA;
   localparam int INST_BYTES = BIT_INST / 8;
   localparam int DATA_BYTES = BIT_DATA / 8;
   localparam int BCNT_W     = $clog2(ASM_W / 8 + 1);
   localparam int TO_W       = $clog2(TIMEOUT + 1);
   localparam int HOLD_W     = $clog2(HOLD_CYC + 1);

   // Header type field, bits [7:6] of the first byte of a frame.
   localparam logic [1:0] HDR_END  = 2'b10;
   localparam logic [1:0] HDR_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE,     // waiting for a header byte
      PAYLOAD,  // collecting payload bytes
      ISSUE,    // holding interrupt/io_inst for the core
      GAP       // one low cycle between injected instructions
   } state_t;

   state_t              state;
   state_t              next_state;
   logic                frame_is_data;
   logic [BCNT_W-1:0]   byte_cnt;
   logic [TO_W-1:0]     to_cnt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [ASM_W-1:0]    asm_word;

   logic                accept;
   logic [ASM_W-1:0]    asm_next;
   logic                last_byte;
   logic                timeout_hit;
   logic                hold_done;

   // Handshake, payload decode and next-state selection.
   always_comb begin
      // NOTE: every signal gets a value before any branch, so no latch is inferred.
      rx_ready    = !reset && (state == IDLE || state == PAYLOAD);
      accept      = rx_valid && rx_ready;
      asm_next    = (asm_word << 8) | ASM_W'(rx_byte);
      last_byte   = frame_is_data ? (byte_cnt == BCNT_W'(DATA_BYTES - 1))
                                  : (byte_cnt == BCNT_W'(INST_BYTES - 1));
      // A byte arriving on the timeout cycle wins over the timeout.
      timeout_hit = !accept && (to_cnt == TO_W'(TIMEOUT - 1));
      hold_done   = (hold_cnt == HOLD_W'(HOLD_CYC - 1));
      next_state  = state;
      case (state)
         IDLE:    if (accept && !rx_byte[7]) next_state = PAYLOAD;
         PAYLOAD: begin
            if (accept && last_byte) next_state = frame_is_data ? IDLE : ISSUE;
            else if (timeout_hit)    next_state = IDLE;
         end
         ISSUE:   if (hold_done) next_state = GAP;
         GAP:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Datapath: word assembly, output registers, pulses and counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         frame_is_data <= 1'b0;
         byte_cnt      <= '0;
         to_cnt        <= '0;
         hold_cnt      <= '0;
         asm_word      <= '0;
         interrupt     <= 1'b0;
         io_inst       <= '0;
         io_din        <= '0;
         data_stb      <= 1'b0;
         err           <= 1'b0;
         done          <= 1'b0;
         inst_cnt      <= '0;
      end else begin
         data_stb <= 1'b0;
         err      <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  done          <= (rx_byte[7:6] == HDR_END);
                  err           <= (rx_byte[7:6] == HDR_RSVD);
                  frame_is_data <= rx_byte[6];
                  byte_cnt      <= '0;
                  to_cnt        <= '0;
               end
            end
            PAYLOAD: begin
               if (accept) begin
                  asm_word <= asm_next;
                  byte_cnt <= byte_cnt + BCNT_W'(1);
                  to_cnt   <= '0;
                  if (last_byte) begin
                     if (frame_is_data) begin
                        io_din   <= asm_next[BIT_DATA-1:0];
                        data_stb <= 1'b1;
                     end else begin
                        io_inst   <= asm_next[BIT_INST-1:0];
                        interrupt <= 1'b1;
                        inst_cnt  <= inst_cnt + 16'd1;
                        hold_cnt  <= '0;
                     end
                  end
               end else if (timeout_hit) begin
                  // Partial word is simply abandoned; outputs keep old values.
                  err <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            ISSUE: begin
               if (hold_done) interrupt <= 1'b0;
               else           hold_cnt  <= hold_cnt + HOLD_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_io_loader.sv
// tb_io_loader: scoreboard bench for io_loader. Stimulus tasks push the
// expected interrupt / data / error events into a queue as frames are
// sent; a negedge monitor pops them when the DUT strobes and also tracks
// the level outputs against a word-level model kept by the stimulus.
module tb_io_loader;

   localparam int BIT_INST   = 32;
   localparam int BIT_DATA   = 32;
   localparam int HOLD_CYC   = 2;
   localparam int TIMEOUT    = 16;
   localparam int INST_BYTES = BIT_INST / 8;
   localparam int DATA_BYTES = BIT_DATA / 8;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                rx_valid = 1'b0;
   logic [7:0]          rx_byte = 8'h00;
   logic                rx_ready;
   logic                interrupt;
   logic [BIT_INST-1:0] io_inst;
   logic [BIT_DATA-1:0] io_din;
   logic                data_stb;
   logic                err;
   logic                done;
   logic [15:0]         inst_cnt;

   io_loader #(
      .BIT_INST(BIT_INST),
      .BIT_DATA(BIT_DATA),
      .HOLD_CYC(HOLD_CYC),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .rx_ready (rx_ready),
      .interrupt(interrupt),
      .io_inst  (io_inst),
      .io_din   (io_din),
      .data_stb (data_stb),
      .err      (err),
      .done     (done),
      .inst_cnt (inst_cnt)
   );

   always #5 clock = ~clock;

   typedef enum int {EV_INST, EV_DATA, EV_ERR} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic [31:0] word;
      int          cyc;
   } ev_t;

   ev_t         sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cycle_cnt = 0;
   int          last_acc_cyc = 0;

   // Word-level model of the level outputs.
   logic [31:0] exp_inst = '0;
   logic [31:0] exp_din = '0;
   logic [15:0] exp_cnt = '0;
   logic        exp_done = 1'b0;

   always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cycle_cnt);
      end
   endtask

   task automatic push(input ev_kind_t k, input logic [31:0] w, input int c);
      ev_t e;
      e.kind = k;
      e.word = w;
      e.cyc  = c;
      sb.push_back(e);
   endtask

   task automatic expect_event(input ev_kind_t k, input logic [31:0] w);
      ev_t e;
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL sb_empty: got event kind %0d word 0x%0h, want none (cycle %0d)", k, w, cycle_cnt);
         return;
      end
      e = sb.pop_front();
      check("event_kind", 64'(k), 64'(e.kind));
      check("event_cycle", 64'(cycle_cnt), 64'(e.cyc));
      if (k != EV_ERR) check("event_word", w, e.word);
   endtask

   // Monitor: level outputs every cycle, strobes against the scoreboard.
   logic prev_int = 1'b0;
   int   width = 0;
   int   low_run = 0;
   always @(negedge clock) begin
      if (reset) begin
         width   = 0;
         low_run = 0;
      end else begin
         check("io_inst", io_inst, exp_inst);
         check("io_din", io_din, exp_din);
         check("inst_cnt", inst_cnt, exp_cnt);
         check("done", done, exp_done);
         if (interrupt && !prev_int) expect_event(EV_INST, io_inst);
         if (interrupt) width++;
         else if (prev_int) begin
            check("int_width", 64'(width), 64'(HOLD_CYC));
            width = 0;
         end
         if (data_stb) expect_event(EV_DATA, io_din);
         if (err) expect_event(EV_ERR, 32'h0);
         if (!rx_ready) low_run++;
         else if (low_run != 0) begin
            check("ready_low_run", 64'(low_run), 64'(HOLD_CYC + 1));
            low_run = 0;
         end
      end
      prev_int = interrupt;
   end

   // Present a byte after 'gap' idle cycles and hold it until accepted.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit acc = 1'b0;
      if (gap > 0) begin
         rx_valid = 1'b0;
         repeat (gap) begin @(posedge clock); #1; end
      end
      rx_valid = 1'b1;
      rx_byte  = b;
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clock);
         acc = rx_ready;
         @(posedge clock);
         #1;
      end
      if (!acc) begin
         vectors++;
         miscompares++;
         $display("FAIL byte_accept: got no rx_ready in 50 cycles, want byte 0x%0h accepted", b);
      end
      last_acc_cyc = cycle_cnt;
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) begin @(posedge clock); #1; end
   endtask

   task automatic send_header(input logic [7:0] h, input int gap);
      send_byte(h, gap);
      exp_done = (h[7:6] == 2'b10);
      if (h[7:6] == 2'b11) push(EV_ERR, 32'h0, last_acc_cyc);
   endtask

   task automatic send_payload(input logic [31:0] w, input int nbytes, input int max_gap);
      logic [31:0] sh = w;
      for (int i = 0; i < nbytes; i++) begin
         send_byte(sh[31:24], $urandom_range(max_gap, 0));
         sh = sh << 8;
      end
   endtask

   task automatic send_word(input bit is_data, input logic [31:0] w, input int max_gap, input int hdr_gap);
      send_header({1'b0, is_data, 6'($urandom)}, hdr_gap);
      send_payload(w, is_data ? DATA_BYTES : INST_BYTES, max_gap);
      if (is_data) begin
         exp_din = w;
         push(EV_DATA, w, last_acc_cyc);
      end else begin
         exp_inst = w;
         exp_cnt  = exp_cnt + 16'd1;
         push(EV_INST, w, last_acc_cyc);
      end
   endtask

   // Header plus a short payload, then silence until the frame times out.
   task automatic send_abandoned(input bit is_data, input int nbytes);
      send_header({1'b0, is_data, 6'($urandom)}, 1);
      send_payload($urandom, nbytes, 1);
      push(EV_ERR, 32'h0, last_acc_cyc + TIMEOUT);
      idle(TIMEOUT + 2);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      rx_valid = 1'b0;
      @(posedge clock);
      #1;
      exp_inst = '0;
      exp_din  = '0;
      exp_cnt  = '0;
      exp_done = 1'b0;
      @(negedge clock);
      check("rst_interrupt", interrupt, 1'b0);
      check("rst_io_inst", io_inst, '0);
      check("rst_io_din", io_din, '0);
      check("rst_data_stb", data_stb, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_inst_cnt", inst_cnt, '0);
      check("rst_rx_ready", rx_ready, 1'b0);
      check("rst_sb_empty", 64'(sb.size()), 64'd0);
      sb.delete();
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of run, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset();

      // Single instruction frame.
      send_word(1'b0, 32'hDEADBEEF, 0, 0);
      idle(6);

      // Single data frame; rx_ready must stay high throughout.
      send_word(1'b1, 32'h12345678, 0, 0);
      idle(3);

      // Timeout mid-frame, then a good frame.
      send_header(8'h00, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      push(EV_ERR, 32'h0, last_acc_cyc + TIMEOUT);
      idle(TIMEOUT + 2);
      send_word(1'b0, 32'h01020304, 0, 0);
      idle(6);

      // Reserved header, end-of-load, then a data header clears done.
      send_header(8'hC0, 1);
      send_header(8'h80, 1);
      idle(5);
      send_word(1'b1, 32'hA5A55A5A, 1, 1);
      idle(3);

      // Reset in the middle of a frame.
      send_header(8'h00, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      do_reset();
      send_word(1'b0, 32'h0000002A, 0, 0);
      idle(6);

      // Back-to-back instruction frames with rx_valid held high.
      send_word(1'b0, 32'h87654321, 0, 0);
      send_word(1'b0, 32'h0BADF00D, 0, 0);
      idle(6);

      // Byte arriving exactly on the timeout cycle must win.
      send_header(8'h00, 2);
      send_byte(8'hCA, 0);
      send_byte(8'hFE, TIMEOUT - 1);
      send_byte(8'hF0, 0);
      send_byte(8'h0D, TIMEOUT - 1);
      exp_inst = 32'hCAFEF00D;
      exp_cnt  = exp_cnt + 16'd1;
      push(EV_INST, 32'hCAFEF00D, last_acc_cyc);
      idle(6);

      // Randomised mix of frames, control headers and abandoned frames.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(5, 0))
            0, 1:    send_word(1'b0, $urandom, 3, $urandom_range(2, 0));
            2, 3:    send_word(1'b1, $urandom, 3, $urandom_range(2, 0));
            4:       send_header({2'b10, 6'($urandom)}, $urandom_range(2, 0));
            default: begin
               if ($urandom_range(1, 0) == 1) send_header({2'b11, 6'($urandom)}, 1);
               else send_abandoned(1'($urandom), $urandom_range(3, 0));
            end
         endcase
      end
      idle(10);

      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
